// File: rtl/mole_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mole_scheduler_pkg
// Purpose  : Shared state encoding, LFSR taps and scoring constants for the
//            whack-a-mole round scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package mole_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPAWN  = 3'd1,
        S_ACTIVE = 3'd2,
        S_GAP    = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    // x^24 + x^23 + x^22 + x^17 + 1, right-shifting Galois form
    localparam logic [23:0] c_LFSR_TAPS    = 24'hE10000;
    localparam logic [1:0]  c_SCORE_PART   = 2'd1;
    localparam logic [1:0]  c_SCORE_FULL   = 2'd2;
    localparam int          c_MIN_UP_TICKS = 2;

    function automatic logic [23:0] lfsr_next(input logic [23:0] s);
        return s[0] ? ((s >> 1) ^ c_LFSR_TAPS) : (s >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mole_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : mole_lfsr
// Purpose  : 24-bit Galois LFSR, free-running while enabled.
// Revision : 1.0 - initial release
// ============================================================================
module mole_lfsr
    import mole_scheduler_pkg::*;
#(
    parameter logic [23:0] SEED = 24'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    output logic [23:0] o_state
);

    logic [23:0] r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/mole_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mole_scheduler
// Purpose  : Whack-a-mole game sequencer: spawns random mole sets, times rounds,
//            keeps score and lives. Define MOLE_SPEEDUP_EN to shorten rounds
//            after every full clear.
// Revision : 1.0 - initial release
// ============================================================================
module mole_scheduler
    import mole_scheduler_pkg::*;
#(
    parameter int          NUM_HOLES = 18,
    parameter int          UP_TICKS  = 8,
    parameter int          GAP_TICKS = 2,
    parameter logic [3:0]  LIVES     = 4'd3,
    parameter int          SCORE_W   = 10,
    parameter logic [23:0] LFSR_SEED = 24'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 tick,
    input  logic                 non_full_clear_hit,
    input  logic                 full_clear_hit,
    input  logic                 miss,
    output logic [NUM_HOLES-1:0] mole_positions,
    output logic                 game_in_progress,
    output logic [SCORE_W-1:0]   score,
    output logic [3:0]           lives,
    output logic                 game_over
);

    localparam int c_TMAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
    localparam int c_TW   = $clog2(c_TMAX + 1);

    localparam logic [c_TW-1:0]      c_T_ONE    = c_TW'(1);
    localparam logic [c_TW-1:0]      c_UP_INIT  = c_TW'(UP_TICKS);
    localparam logic [c_TW-1:0]      c_GAP_INIT = c_TW'(GAP_TICKS);
    localparam logic [SCORE_W-1:0]   c_SCORE_MAX = '1;
    localparam logic [NUM_HOLES-1:0] c_HOLE0    = NUM_HOLES'(1);
`ifdef MOLE_SPEEDUP_EN
    localparam logic [c_TW-1:0]      c_UP_FLOOR = c_TW'(c_MIN_UP_TICKS);
`endif

    state_t                 r_state;
    logic [NUM_HOLES-1:0]   r_moles;
    logic [SCORE_W-1:0]     r_score;
    logic [3:0]             r_lives;
    logic [c_TW-1:0]        r_timer;
    logic [c_TW-1:0]        r_up;

    state_t                 w_state_nxt;
    logic [NUM_HOLES-1:0]   w_moles_nxt;
    logic [SCORE_W-1:0]     w_score_nxt;
    logic [3:0]             w_lives_nxt;
    logic [c_TW-1:0]        w_timer_nxt;
    logic [c_TW-1:0]        w_up_nxt;

    logic [23:0]            w_lfsr;
    logic                   w_unused_lfsr;
    logic [NUM_HOLES-1:0]   w_lfsr_slice;
    logic [NUM_HOLES-1:0]   w_spawn_mask;
    logic                   w_timeout;
    logic [1:0]             w_loss;
    logic [3:0]             w_lives_dec;
    logic [SCORE_W:0]       w_sum_part;
    logic [SCORE_W:0]       w_sum_full;
    logic [SCORE_W-1:0]     w_score_part;
    logic [SCORE_W-1:0]     w_score_full;

    mole_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (reset),
        .i_en    (1'b1),
        .o_state (w_lfsr)
    );

    // Only the low NUM_HOLES bits pick moles; the rest just feed the sequence.
    assign w_unused_lfsr = ^w_lfsr;
    assign w_lfsr_slice  = w_lfsr[NUM_HOLES-1:0];
    assign w_spawn_mask  = (w_lfsr_slice == '0) ? c_HOLE0 : w_lfsr_slice;

    assign w_sum_part   = {1'b0, r_score} + (SCORE_W+1)'(c_SCORE_PART);
    assign w_sum_full   = {1'b0, r_score} + (SCORE_W+1)'(c_SCORE_FULL);
    assign w_score_part = w_sum_part[SCORE_W] ? c_SCORE_MAX : w_sum_part[SCORE_W-1:0];
    assign w_score_full = w_sum_full[SCORE_W] ? c_SCORE_MAX : w_sum_full[SCORE_W-1:0];

    // A full clear on the timeout tick rescues the round, so it costs no life.
    assign w_timeout   = (r_state == S_ACTIVE) && tick && (r_timer == c_T_ONE);
    assign w_loss      = {1'b0, miss} + {1'b0, w_timeout & ~full_clear_hit};
    assign w_lives_dec = (r_lives > {2'b00, w_loss}) ? (r_lives - {2'b00, w_loss}) : 4'd0;

    always_comb begin
        w_state_nxt = r_state;
        w_moles_nxt = r_moles;
        w_score_nxt = r_score;
        w_lives_nxt = r_lives;
        w_timer_nxt = r_timer;
        w_up_nxt    = r_up;

        case (r_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    w_state_nxt = S_SPAWN;
                    w_score_nxt = '0;
                    w_lives_nxt = LIVES;
                    w_up_nxt    = c_UP_INIT;
                    w_moles_nxt = '0;
                end
            end

            S_SPAWN: begin
                w_moles_nxt = w_spawn_mask;
                w_timer_nxt = r_up;
                w_state_nxt = S_ACTIVE;
            end

            S_ACTIVE: begin
                if (tick && !w_timeout) begin
                    w_timer_nxt = r_timer - c_T_ONE;
                end
                if (full_clear_hit) begin
                    w_score_nxt = w_score_full;
                    w_moles_nxt = '0;
                    w_timer_nxt = c_GAP_INIT;
                    w_state_nxt = S_GAP;
`ifdef MOLE_SPEEDUP_EN
                    if (r_up > c_UP_FLOOR) begin
                        w_up_nxt = r_up - c_T_ONE;
                    end
`endif
                end else begin
                    if (non_full_clear_hit) begin
                        w_score_nxt = w_score_part;
                    end
                    if (w_timeout) begin
                        w_moles_nxt = '0;
                        w_timer_nxt = c_GAP_INIT;
                        w_state_nxt = S_GAP;
                    end
                end
                w_lives_nxt = w_lives_dec;
                // Running out of lives overrides every other transition.
                if ((w_loss != 2'd0) && (w_lives_dec == 4'd0)) begin
                    w_state_nxt = S_OVER;
                    w_moles_nxt = '0;
                end
            end

            S_GAP: begin
                w_moles_nxt = '0;
                if (tick) begin
                    w_timer_nxt = r_timer - c_T_ONE;
                    if (r_timer == c_T_ONE) begin
                        w_state_nxt = S_SPAWN;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_moles_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_moles <= '0;
            r_score <= '0;
            r_lives <= LIVES;
            r_timer <= '0;
            r_up    <= c_UP_INIT;
        end else begin
            r_state <= w_state_nxt;
            r_moles <= w_moles_nxt;
            r_score <= w_score_nxt;
            r_lives <= w_lives_nxt;
            r_timer <= w_timer_nxt;
            r_up    <= w_up_nxt;
        end
    end

    assign mole_positions   = r_moles;
    assign score            = r_score;
    assign lives            = r_lives;
    assign game_over        = (r_state == S_OVER);
    assign game_in_progress = (r_state == S_SPAWN) || (r_state == S_ACTIVE) ||
                              (r_state == S_GAP);

endmodule
`default_nettype wire

// File: tb/tb_mole_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mole_scheduler
// Purpose  : Self-checking bench: directed vector table, hand-written corner
//            sequences and randomized play against a behavioural game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mole_scheduler;
    import mole_scheduler_pkg::*;

    localparam int         NH   = 18;
    localparam int         UPT  = 8;
    localparam int         GAPT = 2;
    localparam logic [3:0] LV   = 4'd3;
    localparam int         SW   = 10;
    localparam int         SMAX = (1 << SW) - 1;
    localparam logic [23:0] SEED = 24'hACE1;
`ifdef MOLE_SPEEDUP_EN
    localparam int         UP2  = UPT - 1;
`else
    localparam int         UP2  = UPT;
`endif

    localparam int P_IDLE = 0, P_SPAWN = 1, P_ACTIVE = 2, P_GAP = 3, P_OVER = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, tick, nfc, fc, miss;
    logic [NH-1:0] mole_positions;
    logic          game_in_progress;
    logic [SW-1:0] score;
    logic [3:0]    lives;
    logic          game_over;

    mole_scheduler #(
        .NUM_HOLES (NH),
        .UP_TICKS  (UPT),
        .GAP_TICKS (GAPT),
        .LIVES     (LV),
        .SCORE_W   (SW),
        .LFSR_SEED (SEED)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .tick               (tick),
        .non_full_clear_hit (nfc),
        .full_clear_hit     (fc),
        .miss               (miss),
        .mole_positions     (mole_positions),
        .game_in_progress   (game_in_progress),
        .score              (score),
        .lives              (lives),
        .game_over          (game_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural game model
    int          m_phase, m_score, m_lives, m_timer, m_up;
    logic [23:0] m_lfsr;
    logic [NH-1:0] m_moles;

    typedef struct {
        logic st, tk, nfc, fc, ms;
        int   gip, over, sc, lv, nz;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_score = 0; m_lives = LV; m_timer = 0;
        m_up = UPT; m_lfsr = SEED; m_moles = '0;
    endtask

    task automatic model_step(input logic st, tk, h_part, h_full, ms);
        logic [23:0] snap;
        int loss;
        logic timeout;
        snap   = m_lfsr;
        m_lfsr = snap[0] ? ((snap >> 1) ^ c_LFSR_TAPS) : (snap >> 1);
        case (m_phase)
            P_IDLE, P_OVER: if (st) begin
                m_phase = P_SPAWN; m_score = 0; m_lives = LV; m_up = UPT;
            end
            P_SPAWN: begin
                m_moles = snap[NH-1:0];
                if (m_moles == 0) m_moles = 1;
                m_timer = m_up;
                m_phase = P_ACTIVE;
            end
            P_ACTIVE: begin
                timeout = tk && (m_timer == 1);
                if (tk) m_timer = m_timer - 1;
                loss = ms ? 1 : 0;
                if (h_full) begin
                    m_score = (m_score + 2 > SMAX) ? SMAX : m_score + 2;
                    m_moles = '0; m_timer = GAPT; m_phase = P_GAP;
`ifdef MOLE_SPEEDUP_EN
                    if (m_up > 2) m_up = m_up - 1;
`endif
                end else begin
                    if (h_part) m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
                    if (timeout) begin
                        loss++; m_moles = '0; m_timer = GAPT; m_phase = P_GAP;
                    end
                end
                if (loss > 0) begin
                    m_lives = (m_lives - loss < 0) ? 0 : m_lives - loss;
                    if (m_lives == 0) begin m_phase = P_OVER; m_moles = '0; end
                end
            end
            P_GAP: if (tk) begin
                if (m_timer == 1) m_phase = P_SPAWN;
                m_timer = m_timer - 1;
            end
            default: ;
        endcase
    endtask

    // Called #1 after a rising edge; returns #1 after the next one.
    task automatic step(input logic st, tk, h_part, h_full, ms);
        start = st; tick = tk; nfc = h_part; fc = h_full; miss = ms;
        @(posedge clk);
        model_step(st, tk, h_part, h_full, ms);
        #1;
    endtask

    task automatic check_model();
        chk("moles", int'(mole_positions), int'(m_moles));
        chk("game_in_progress", int'(game_in_progress),
            int'(m_phase == P_SPAWN || m_phase == P_ACTIVE || m_phase == P_GAP));
        chk("game_over", int'(game_over), int'(m_phase == P_OVER));
        chk("score", int'(score), m_score);
        chk("lives", int'(lives), m_lives);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_moles"}, int'(mole_positions), 0);
        chk({tag, "_gip"}, int'(game_in_progress), 0);
        chk({tag, "_over"}, int'(game_over), 0);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_lives"}, int'(lives), int'(LV));
    endtask

    task automatic add(input logic st, tk, h_part, h_full, ms,
                       input int gip, over, sc, lv, nz);
        vec_t v;
        v.st = st; v.tk = tk; v.nfc = h_part; v.fc = h_full; v.ms = ms;
        v.gip = gip; v.over = over; v.sc = sc; v.lv = lv; v.nz = nz;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1; start = 0; tick = 0; nfc = 0; fc = 0; miss = 0;
        model_reset();

        //        st tk nf fc ms  gip ov sc lv nz
        add(1, 0, 0, 0, 0,  1, 0, 0, 3, 0);   // SPAWN
        add(0, 0, 0, 0, 0,  1, 0, 0, 3, 1);   // ACTIVE, moles up
        add(0, 0, 1, 0, 0,  1, 0, 1, 3, 1);   // partial hit
        add(0, 0, 0, 1, 0,  1, 0, 3, 3, 0);   // full clear -> GAP
        add(0, 1, 0, 0, 0,  1, 0, 3, 3, 0);
        add(0, 1, 0, 0, 0,  1, 0, 3, 3, 0);   // -> SPAWN
        add(0, 0, 0, 0, 0,  1, 0, 3, 3, 1);   // ACTIVE
        for (int i = 1; i < UP2; i++) add(0, 1, 0, 0, 0, 1, 0, 3, 3, 1);
        add(0, 1, 0, 0, 0,  1, 0, 3, 2, 0);   // timeout -> GAP, life lost
        add(0, 1, 0, 0, 0,  1, 0, 3, 2, 0);
        add(0, 1, 0, 0, 0,  1, 0, 3, 2, 0);   // -> SPAWN
        add(0, 0, 0, 0, 0,  1, 0, 3, 2, 1);
        add(0, 0, 0, 0, 1,  1, 0, 3, 1, 1);   // miss
        add(0, 0, 1, 0, 1,  0, 1, 4, 0, 0);   // hit + miss, last life -> OVER
        add(0, 0, 0, 1, 0,  0, 1, 4, 0, 0);   // hits ignored in OVER
        add(0, 1, 0, 0, 1,  0, 1, 4, 0, 0);
        add(1, 0, 0, 0, 0,  1, 0, 0, 3, 0);   // restart
        add(0, 1, 0, 0, 0,  1, 0, 0, 3, 1);

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        step(0, 1, 1, 1, 1);                  // inputs ignored in IDLE
        check_model();

        foreach (tbl[i]) begin
            step(tbl[i].st, tbl[i].tk, tbl[i].nfc, tbl[i].fc, tbl[i].ms);
            chk($sformatf("tbl%0d_gip", i), int'(game_in_progress), tbl[i].gip);
            chk($sformatf("tbl%0d_over", i), int'(game_over), tbl[i].over);
            chk($sformatf("tbl%0d_score", i), int'(score), tbl[i].sc);
            chk($sformatf("tbl%0d_lives", i), int'(lives), tbl[i].lv);
            chk($sformatf("tbl%0d_nz", i), int'(mole_positions != '0), tbl[i].nz);
            chk($sformatf("tbl%0d_model", i), int'(mole_positions), int'(m_moles));
        end

        // Full clear landing on the timeout tick
        for (int i = 1; i < UPT; i++) begin
            step(0, 1, 0, 0, 0);
            check_model();
        end
        step(0, 1, 0, 1, 0);
        chk("fc_on_timeout_score", int'(score), 2);
        chk("fc_on_timeout_lives", int'(lives), 3);
        chk("fc_on_timeout_moles", int'(mole_positions), 0);
        chk("fc_on_timeout_gip", int'(game_in_progress), 1);

        // Drive the score up to the saturation point
        for (int r = 0; r < 510; r++) begin
            step(0, 1, 0, 0, 0);
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 1, 0);
            check_model();
        end
        chk("score_1022", int'(score), 1022);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("score_1023", int'(score), 1023);
        step(0, 0, 0, 1, 0);
        chk("score_sat", int'(score), 1023);
        chk("score_sat_lives", int'(lives), 3);

        // Asynchronous reset in the middle of ACTIVE
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("pre_reset_active", int'(mole_positions != '0), 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midreset");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1, 0);
            check_model();
        end

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            int h;
            h = $urandom_range(0, 99);
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
                 (h < 12), (h >= 12 && h < 20), ($urandom_range(0, 15) == 0));
            check_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 Parameter NUM_HOLES, default 18, number of holes/switches/mole bits.
REQ-002 Parameter UP_TICKS, default 8, ticks a mole set stays up per round.
REQ-003 Parameter GAP_TICKS, default 2, ticks with no moles between rounds.
REQ-004 Parameter LIVES, default 3, lives per game, width 4.
REQ-005 Parameter SCORE_W, default 10, score width.
REQ-006 Parameter LFSR_SEED, default 24'hACE1, nonzero LFSR seed.
REQ-007 clk  input  1  system clock (50 MHz); one clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  one-cycle pulse; begins a new game from IDLE or OVER.
REQ-010 tick  input  1  one-cycle timebase enable; all timers count only on tick.
REQ-011 non_full_clear_hit  input  1  pulse from hit logic: partial hit.
REQ-012 full_clear_hit  input  1  pulse from hit logic: all current moles hit.
REQ-013 miss  input  1  pulse from hit logic: switch raised on empty hole.
REQ-014 mole_positions  output  NUM_HOLES  one-hot-or-more mask of raised moles, to hit logic.
REQ-015 game_in_progress  output  1  high from SPAWN through GAP; to hit logic.
REQ-016 score  output  SCORE_W  current score.
REQ-017 lives  output  4  remaining lives.
REQ-018 game_over  output  1  high while in OVER.

Function
REQ-019 FSM states SHALL be IDLE, SPAWN, ACTIVE, GAP, OVER.
REQ-020 IDLE/OVER + start SHALL go to SPAWN next cycle, loading score=0, lives=LIVES, up_time=UP_TICKS.
REQ-021 SPAWN lasts exactly one cycle: mole_positions <= LFSR[NUM_HOLES-1:0], forced to bit 0 set if that slice is zero; timer <= up_time; next ACTIVE.
REQ-022 ACTIVE: each tick decrements timer; tick with timer==1 is a timeout.
REQ-023 ACTIVE + full_clear_hit: score += 2, mole_positions <= 0, timer <= GAP_TICKS, next GAP.
REQ-024 ACTIVE + non_full_clear_hit: score += 1, stay ACTIVE, mole_positions unchanged.
REQ-025 ACTIVE + miss: lives -= 1; timeout: lives -= 1 and next GAP.
REQ-026 Any decrement reaching lives==0 SHALL go to OVER next cycle, overriding other transitions.
REQ-027 Same-cycle full_clear_hit and timeout: full clear wins, no life lost.
REQ-028 Same-cycle hit and miss: both applied (score and life) in that cycle.
REQ-029 Score SHALL saturate at 2^SCORE_W-1; lives never below 0.
REQ-030 GAP: mole_positions=0; after GAP_TICKS ticks next SPAWN.
REQ-031 hit/miss inputs outside ACTIVE SHALL be ignored; start outside IDLE/OVER ignored.
REQ-032 24-bit Galois LFSR advances every cycle, independent of state.
REQ-033 OVER: mole_positions=0, game_in_progress=0, game_over=1; score and lives held.

Reset
REQ-034 Reset SHALL force IDLE, mole_positions=0, game_in_progress=0, game_over=0, score=0, lives=LIVES, timers=0, LFSR=LFSR_SEED, immediately and mid-game.

Configuration
REQ-035 Macro MOLE_SPEEDUP_EN defined: each full clear decrements up_time by 1, floor 2; restored to UP_TICKS on start.
REQ-036 Macro undefined: up_time constant UP_TICKS.

Structure
REQ-037 Shared package SHALL hold the state enum, LFSR taps constant, score increments (1, 2) and minimum up_time (2).
REQ-038 LFSR SHALL be a sub-module mole_lfsr (seed parameter, enable, state output).

Verification
REQ-039 reset, start, tick every 4 clk -> SPAWN 1 cycle, ACTIVE with nonzero mole_positions, game_in_progress=1, lives=3, score=0.
REQ-040 ACTIVE, no hits, 8 ticks -> lives=2, mole_positions=0 for 2 ticks, then new SPAWN.
REQ-041 non_full_clear_hit then full_clear_hit -> score=1 then 3, GAP entered; with MOLE_SPEEDUP_EN next timer loads 7.
REQ-042 Three miss pulses -> lives 2,1,0, OVER with game_over=1, mole_positions=0; start -> score=0, lives=3.
REQ-043 full_clear_hit on the timeout tick -> score+2, lives unchanged; score at 1023 + full clear -> stays 1023 (SCORE_W=10).
REQ-044 reset asserted mid-ACTIVE -> same cycle outputs at reset values; released -> IDLE until start.
